// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int BYTE_W = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side and serializer-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_tx_arbiter_pkg::*;

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic [ID_W-1:0]           cur_id;
  logic                      err;

  // Arbiter side.
  modport master (
    input  req, req_data, tx_done,
    output ack, tx_start, tx_data, busy, cur_id, err
  );

  // Producers plus serializer side.
  modport slave (
    output req, req_data, tx_done,
    input  ack, tx_start, tx_data, busy, cur_id, err
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin arbiter: priority pointer plus first-set search from the pointer.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int ID_W = id_width(N)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic [N-1:0]    req_i,
  input  logic            advance_i,
  input  logic [ID_W-1:0] last_id_i,
  output logic            gnt_valid_o,
  output logic [ID_W-1:0] gnt_id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;

  // Pointer moves to the slot just after the last served requester.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (last_id_i == ID_W'(N - 1)) ? '0 : last_id_i + ID_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Scan from the farthest slot back to the pointer so the nearest set bit wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    idx         = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr_q) + i) % N);
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers.
//   state | meaning
//   IDLE  | waiting for a request while tx_done is low
//   SEND  | tx_start held with the latched byte until done rises or timeout
//   DRAIN | waiting for tx_done to fall before the next grant
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst_l,
  uart_tx_arbiter_if.master bus
);

  localparam int ID_W    = id_width(NUM_REQ);
  localparam bit TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int TO_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = TO_EN ? TIMEOUT_CYCLES - 1 : 0;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                err_q, err_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                done_q;

  logic                done_rise;
  logic                timeout_hit;
  logic                advance;
  logic                gnt_valid;
  logic [ID_W-1:0]     gnt_id;

  assign done_rise   = bus.tx_done & ~done_q;
  assign timeout_hit = TO_EN && (to_cnt_q == TO_W'(TO_LAST));

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk         (clk),
    .rst_l       (rst_l),
    .req_i       (bus.req),
    .advance_i   (advance),
    .last_id_i   (cur_id_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Next-state and registered-output logic; the timeout counter
  // counts SEND cycles so tx_start stays high for exactly TIMEOUT_CYCLES.
  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    ack_d      = '0;
    err_d      = 1'b0;
    to_cnt_d   = to_cnt_q;
    advance    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid && !bus.tx_done) begin
          cur_id_d   = gnt_id;
          tx_data_d  = bus.req_data[{gnt_id, 3'b000} +: BYTE_W];
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (done_rise) begin
          tx_start_d      = 1'b0;
          ack_d[cur_id_q] = 1'b1;
          advance         = 1'b1;
          state_d         = DRAIN;
        end else if (timeout_hit) begin
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          advance    = 1'b1;
          state_d    = DRAIN;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      DRAIN: begin
        if (!bus.tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= bus.tx_done;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.cur_id   = cur_id_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple serializer model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Serializer model: done rises 40 cycles after start is seen, stays 10 cycles.
  logic model_done = 1'b0;
  logic spur_done  = 1'b0;
  bit   ser_en     = 1'b1;
  int   ser_cnt    = 0;
  int   ser_starts = 0;

  assign bus.tx_done = model_done | spur_done;

  always @(posedge clk) begin
    if (!rst_l) begin
      ser_cnt    <= 0;
      model_done <= 1'b0;
    end else if (ser_cnt == 0) begin
      if (bus.tx_start && ser_en) begin
        ser_cnt    <= 1;
        ser_starts <= ser_starts + 1;
      end
    end else begin
      ser_cnt <= ser_cnt + 1;
      if (ser_cnt == 40) model_done <= 1'b1;
      if (ser_cnt == 50) begin
        model_done <= 1'b0;
        ser_cnt    <= 0;
      end
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ack(input string name, output logic [3:0] a);
    bit found = 1'b0;
    a = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.ack != 0) begin
        found = 1'b1;
        a = bus.ack;
        break;
      end
    end
    check({name, "_ack_seen"}, found, 1);
  endtask

  task automatic wait_idle(input string name);
    bit found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus.busy) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, found, 1);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  id;
    logic [7:0]  byte_v;
    logic [3:0]  req_after;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [3:0] a;
    bit         ok;
    int         hi;

    vecs[0] = '{4'b1111, 32'h4332_2110, 2'd0, 8'h10, 4'b1111};
    vecs[1] = '{4'b1111, 32'h4332_2110, 2'd1, 8'h21, 4'b1111};
    vecs[2] = '{4'b1111, 32'h4332_2110, 2'd2, 8'h32, 4'b1111};
    vecs[3] = '{4'b1111, 32'h4332_2110, 2'd3, 8'h43, 4'b1111};
    vecs[4] = '{4'b1111, 32'h4332_2110, 2'd0, 8'h10, 4'b0000};
    vecs[5] = '{4'b0100, 32'h00A5_0000, 2'd2, 8'hA5, 4'b0000};
    vecs[6] = '{4'b1001, 32'h7700_0066, 2'd3, 8'h77, 4'b0001};
    vecs[7] = '{4'b0001, 32'h7700_0066, 2'd0, 8'h66, 4'b0000};

    bus.req      = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_err", bus.err, 0);
    check("rst_cur_id", bus.cur_id, 0);
    check("rst_tx_data", bus.tx_data, 0);
    rst_l = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      bus.req      = vecs[v].req;
      bus.req_data = vecs[v].data;
      @(negedge clk);
      check($sformatf("v%0d_start", v), bus.tx_start, 1);
      check($sformatf("v%0d_cur_id", v), bus.cur_id, vecs[v].id);
      check($sformatf("v%0d_tx_data", v), bus.tx_data, vecs[v].byte_v);
      check($sformatf("v%0d_busy", v), bus.busy, 1);
      ok = 1'b1;
      a  = '0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        if (bus.ack != 0) begin
          a = bus.ack;
          break;
        end
        if (!bus.tx_start || bus.tx_data != vecs[v].byte_v) ok = 1'b0;
      end
      check($sformatf("v%0d_hold", v), ok, 1);
      check($sformatf("v%0d_ack", v), a, 4'b0001 << vecs[v].id);
      check($sformatf("v%0d_start_drop", v), bus.tx_start, 0);
      bus.req = vecs[v].req_after;
      @(negedge clk);
      check($sformatf("v%0d_ack_one", v), bus.ack, 0);
      wait_idle($sformatf("v%0d", v));
      check($sformatf("v%0d_starts", v), ser_starts, v + 1);
    end

    // Spurious done while idle.
    ok = 1'b1;
    spur_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.ack != 0 || bus.busy) ok = 1'b0;
    end
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_ignored", ok, 1);

    // Request dropped right after the grant.
    bus.req      = 4'b0010;
    bus.req_data = 32'h0000_5A00;
    @(negedge clk);
    bus.req = '0;
    check("drop_start", bus.tx_start, 1);
    check("drop_cur_id", bus.cur_id, 1);
    check("drop_tx_data", bus.tx_data, 8'h5A);
    wait_ack("drop", a);
    check("drop_ack", a, 4'b0010);
    wait_idle("drop");
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bus.tx_start) ok = 1'b0;
    end
    check("drop_no_second", ok, 1);
    check("drop_starts", ser_starts, 9);

    // Timeout: serializer never answers.
    ser_en       = 1'b0;
    bus.req      = 4'b0101;
    bus.req_data = 32'h00C3_003C;
    @(negedge clk);
    check("to_cur_id", bus.cur_id, 2);
    hi = bus.tx_start ? 1 : 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.tx_start) hi++;
      else break;
    end
    check("to_start_cycles", hi, TO);
    check("to_err", bus.err, 1);
    check("to_no_ack", bus.ack, 0);
    check("to_busy_drain", bus.busy, 1);
    bus.req = 4'b0001;
    ser_en  = 1'b1;
    @(negedge clk);
    check("to_err_one", bus.err, 0);
    @(negedge clk);
    check("to_next_start", bus.tx_start, 1);
    check("to_next_id", bus.cur_id, 0);
    check("to_next_data", bus.tx_data, 8'h3C);
    wait_ack("to_next", a);
    check("to_next_ack", a, 4'b0001);
    bus.req = '0;
    wait_idle("to_next");
    check("to_starts", ser_starts, 10);

    // Reset in the middle of SEND.
    bus.req      = 4'b1001;
    bus.req_data = 32'hD400_00E7;
    @(negedge clk);
    check("rs_start", bus.tx_start, 1);
    check("rs_cur_id", bus.cur_id, 3);
    repeat (19) @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    check("rs_tx_start", bus.tx_start, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_ack", bus.ack, 0);
    check("rs_cur_id0", bus.cur_id, 0);
    check("rs_tx_data", bus.tx_data, 0);
    check("rs_err", bus.err, 0);
    rst_l = 1'b1;
    @(negedge clk);
    check("rs_regrant", bus.tx_start, 1);
    check("rs_regrant_id", bus.cur_id, 0);
    check("rs_regrant_data", bus.tx_data, 8'hE7);
    wait_ack("rs", a);
    check("rs_ack_id", a, 4'b0001);
    bus.req = '0;
    wait_idle("rs");
    check("rs_starts", ser_starts, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
